// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO responder: region select,
// MMIO register offsets and timer control bit positions.
package dmem_pkg;

  // Addr bit that selects the MMIO page instead of RAM.
  localparam int MMIO_SEL_BIT = 31;

  // MMIO byte offsets within the page (Addr[4:0] with [1:0] forced to 0).
  localparam logic [4:0] OFF_LEDS  = 5'h00;
  localparam logic [4:0] OFF_SW    = 5'h04;
  localparam logic [4:0] OFF_TCNT  = 5'h08;
  localparam logic [4:0] OFF_TCMP  = 5'h0C;
  localparam logic [4:0] OFF_TCTRL = 5'h10;
  localparam logic [4:0] OFF_TSTAT = 5'h14;

  // TCTRL bit positions.
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_W     = 3;

  // Word-aligned MMIO byte offset taken from a full byte address.
  function automatic logic [4:0] mmio_offset(input logic [31:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Programmable cycle timer: count, compare, control and sticky match flag.
// Per-cycle priority: software TCNT write, then match (reload or
// increment), then plain increment while enabled; disabled timer holds.
module mmio_timer
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tcnt_we,
  input  logic              tcmp_we,
  input  logic              tctrl_we,
  input  logic              tstat_we,
  input  logic [31:0]       wdata,
  output logic [31:0]       tcnt,
  output logic [31:0]       tcmp,
  output logic [CTRL_W-1:0] tctrl,
  output logic              match,
  output logic              irq
);

  logic        en;
  logic        hit;
  logic        match_set;
  logic        match_clr;
  logic [31:0] tcnt_next;

  assign en = tctrl[CTRL_EN];
  assign hit = en && (tcnt == tcmp);
  // A software count write takes the whole cycle, so it also masks the match.
  assign match_set = hit && !tcnt_we;
  assign match_clr = tstat_we && wdata[0];

  // Next count value following the priority order above.
  always_comb begin
    tcnt_next = tcnt;
    if (tcnt_we) begin
      tcnt_next = wdata;
    end else if (hit) begin
      tcnt_next = tctrl[CTRL_AR] ? 32'h0 : tcnt + 32'h1;
    end else if (en) begin
      tcnt_next = tcnt + 32'h1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt_next;
    end
  end

  // Compare and control registers, software written only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcmp  <= '0;
      tctrl <= '0;
    end else begin
      if (tcmp_we) tcmp <= wdata;
      if (tctrl_we) tctrl <= wdata[CTRL_W-1:0];
    end
  end

  // Sticky match flag: a new match beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match <= 1'b0;
    end else if (match_set) begin
      match <= 1'b1;
    end else if (match_clr) begin
      match <= 1'b0;
    end
  end

  assign irq = match & tctrl[CTRL_IRQEN];

endmodule

// File: rtl/dmem_mmio_responder.sv
// Memory-side responder for the single-cycle core: word RAM below
// 0x8000_0000, MMIO page (LEDs, synchronised switches, timer) above.
// Loads are combinational from Addr; stores land on the rising edge.
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int    RAM_WORDS = 64,
  parameter int    LED_W     = 8,
  parameter int    SW_W      = 8,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] leds,
  output logic             irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0]       mem [RAM_WORDS];
  logic [IDX_W-1:0]  ram_idx;
  logic              is_mmio;
  logic [4:0]        off;
  logic              ram_we;
  logic              mmio_we;
  logic [LED_W-1:0]  leds_q;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [31:0]       leds_ext;
  logic [31:0]       sw_ext;
  logic [31:0]       tcnt;
  logic [31:0]       tcmp;
  logic [CTRL_W-1:0] tctrl;
  logic              match;
  logic              unused_bits;

  // Upper address bits and the byte lane bits are intentionally ignored.
  assign unused_bits = ^{Addr, WriteData};

  assign is_mmio = Addr[MMIO_SEL_BIT];
  assign ram_idx = Addr[IDX_W+1:2];
  assign off     = mmio_offset(Addr);
  assign ram_we  = MemWrite && !is_mmio;
  assign mmio_we = MemWrite && is_mmio;

  // RAM store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= WriteData;
    end
  end

  // LED output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q <= '0;
    end else if (mmio_we && off == OFF_LEDS) begin
      leds_q <= WriteData[LED_W-1:0];
    end
  end

  assign leds = leds_q;

  // Two-flop synchroniser for the asynchronous board switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  mmio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .tcnt_we  (mmio_we && off == OFF_TCNT),
    .tcmp_we  (mmio_we && off == OFF_TCMP),
    .tctrl_we (mmio_we && off == OFF_TCTRL),
    .tstat_we (mmio_we && off == OFF_TSTAT),
    .wdata    (WriteData),
    .tcnt     (tcnt),
    .tcmp     (tcmp),
    .tctrl    (tctrl),
    .match    (match),
    .irq      (irq)
  );

  // Zero-extend the narrow registers to the 32-bit read bus.
  always_comb begin
    leds_ext = '0;
    sw_ext   = '0;
    leds_ext[LED_W-1:0] = leds_q;
    sw_ext[SW_W-1:0]    = sw_sync;
  end

  // Combinational load data; a same-cycle store is seen only next cycle.
  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = mem[ram_idx];
    end else begin
      case (off)
        OFF_LEDS:  ReadData = leds_ext;
        OFF_SW:    ReadData = sw_ext;
        OFF_TCNT:  ReadData = tcnt;
        OFF_TCMP:  ReadData = tcmp;
        OFF_TCTRL: ReadData = {{(32-CTRL_W){1'b0}}, tctrl};
        OFF_TSTAT: ReadData = {31'h0, match};
        default:   ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with hand-computed expectations.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_LEDS  = 32'h8000_0000;
  localparam logic [31:0] A_SW    = 32'h8000_0004;
  localparam logic [31:0] A_TCNT  = 32'h8000_0008;
  localparam logic [31:0] A_TCMP  = 32'h8000_000C;
  localparam logic [31:0] A_TCTRL = 32'h8000_0010;
  localparam logic [31:0] A_TSTAT = 32'h8000_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [7:0]  sw = '0;
  logic [7:0]  leds;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  dmem_mmio_responder #(
    .RAM_WORDS (64),
    .LED_W     (8),
    .SW_W      (8),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .sw        (sw),
    .leds      (leds),
    .irq       (irq)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Store through the bus; returns 1 time unit after the capturing edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    WriteData = d;
    MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  // Combinational load.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    MemWrite = 1'b0;
    #1;
    d = ReadData;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    #12;
    reset = 1'b0;
    tick();
    check("rst_leds", {24'h0, leds}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    do_read(A_TCNT, rd);  check("rst_tcnt", rd, 32'h0);
    do_read(A_TCTRL, rd); check("rst_tctrl", rd, 32'h0);

    // RAM store/load, wrap and byte-offset aliasing
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    do_read(32'h0000_0010, rd); check("ram_rd", rd, 32'hDEAD_BEEF);
    do_read(32'h0000_0110, rd); check("ram_wrap", rd, 32'hDEAD_BEEF);
    do_read(32'h0000_0013, rd); check("ram_byteoff", rd, 32'hDEAD_BEEF);

    // Same-cycle read returns old data
    Addr = 32'h0000_0010;
    WriteData = 32'h1234_5678;
    MemWrite = 1'b1;
    #1;
    check("ram_rd_old", ReadData, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    do_read(32'h0000_0010, rd); check("ram_rd_new", rd, 32'h1234_5678);
    do_write(32'h0000_0010, 32'hDEAD_BEEF);

    // LED register and unused MMIO slots
    do_write(A_LEDS, 32'h0000_01A5);
    check("leds_out", {24'h0, leds}, 32'hA5);
    do_read(A_LEDS, rd); check("leds_rd", rd, 32'h0000_00A5);
    do_write(32'h8000_0018, 32'hFFFF_FFFF);
    do_read(32'h8000_0018, rd); check("mmio_18", rd, 32'h0);
    do_read(32'h8000_001C, rd); check("mmio_1c", rd, 32'h0);
    check("leds_kept", {24'h0, leds}, 32'hA5);

    // Asynchronous reset mid-cycle: LEDs clear, RAM preserved
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_leds", {24'h0, leds}, 32'h0);
    do_read(32'h0000_0010, rd); check("rst_ram_kept", rd, 32'hDEAD_BEEF);
    reset = 1'b0;
    tick();

    // Switch synchroniser latency
    sw = 8'h3C;
    do_read(A_SW, rd); check("sw_c0", rd, 32'h0);
    tick();
    do_read(A_SW, rd); check("sw_c1", rd, 32'h0);
    tick();
    do_read(A_SW, rd); check("sw_c2", rd, 32'h3C);
    do_write(A_SW, 32'hFF);
    do_read(A_SW, rd); check("sw_wr_ign", rd, 32'h3C);

    // Timer: compare 5, autoreload with interrupt
    do_write(A_TCMP, 32'd5);
    do_write(A_TCTRL, 32'h7);
    do_write(A_TCNT, 32'd0);
    for (int i = 0; i <= 5; i++) begin
      do_read(A_TCNT, rd);
      check($sformatf("tcnt_%0d", i), rd, i);
      check($sformatf("irq_lo_%0d", i), {31'h0, irq}, 32'h0);
      tick();
    end
    do_read(A_TCNT, rd);  check("tcnt_reload", rd, 32'h0);
    do_read(A_TSTAT, rd); check("match_set", rd, 32'h1);
    check("irq_hi", {31'h0, irq}, 32'h1);
    do_write(A_TSTAT, 32'h1);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    do_read(A_TSTAT, rd); check("match_w1c", rd, 32'h0);
    do_write(A_TCTRL, 32'hFFFF_FFF8);
    do_read(A_TCTRL, rd); check("tctrl_upper0", rd, 32'h0);
    do_read(A_TSTAT, rd); check("match_idle", rd, 32'h0);

    // Match in the same cycle as a W1C: set wins
    do_write(A_TCMP, 32'h20);
    do_write(A_TCNT, 32'h20);
    do_write(A_TCTRL, 32'h5);
    do_write(A_TSTAT, 32'h1);
    do_read(A_TSTAT, rd); check("set_beats_w1c", rd, 32'h1);
    check("irq_set_w1c", {31'h0, irq}, 32'h1);
    do_read(A_TCNT, rd);  check("tcnt_no_ar", rd, 32'h21);
    do_write(A_TSTAT, 32'h1);
    do_read(A_TSTAT, rd); check("match_clr2", rd, 32'h0);

    // TCNT write overrides a same-cycle match with autoreload
    do_write(A_TCTRL, 32'h0);
    do_write(A_TCNT, 32'h40);
    do_write(A_TCMP, 32'h40);
    do_write(A_TCTRL, 32'h3);
    do_write(A_TCNT, 32'h100);
    do_read(A_TCNT, rd); check("tcnt_wr_override", rd, 32'h100);
    tick();
    do_read(A_TCNT, rd); check("tcnt_after_wr", rd, 32'h101);

    // 32-bit wrap with match, IRQEN off
    do_write(A_TCTRL, 32'h0);
    do_write(A_TSTAT, 32'h1);
    do_write(A_TCMP, 32'hFFFF_FFFF);
    do_write(A_TCNT, 32'hFFFF_FFFE);
    do_write(A_TCTRL, 32'h1);
    do_read(A_TCTRL, rd); check("tctrl_rd", rd, 32'h1);
    do_read(A_TCNT, rd);  check("wrap_fe", rd, 32'hFFFF_FFFE);
    tick();
    do_read(A_TCNT, rd);  check("wrap_ff", rd, 32'hFFFF_FFFF);
    do_read(A_TSTAT, rd); check("wrap_nomatch", rd, 32'h0);
    tick();
    do_read(A_TCNT, rd);  check("wrap_00", rd, 32'h0);
    do_read(A_TSTAT, rd); check("wrap_match", rd, 32'h1);
    check("wrap_irq_off", {31'h0, irq}, 32'h0);

    // Enable IRQ on the pending match, then reset mid-operation
    do_write(A_TCTRL, 32'h5);
    check("irq_late_en", {31'h0, irq}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_irq_async", {31'h0, irq}, 32'h0);
    do_read(A_TCNT, rd);  check("rst_tcnt_async", rd, 32'h0);
    do_read(A_TSTAT, rd); check("rst_match_async", rd, 32'h0);
    do_read(A_TCMP, rd);  check("rst_tcmp_async", rd, 32'h0);
    do_read(32'h0000_0010, rd); check("rst_ram_kept2", rd, 32'hDEAD_BEEF);
    reset = 1'b0;
    tick();

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
